// File: rtl/switch_ingress_buffer.sv
// Per-port ingress stage for switch_4port: filters illegal packets, buffers legal ones
// in a small FIFO and holds each packet at the switch port until it is accepted.
module switch_ingress_buffer #(
  parameter int PORT_ID = 0,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [3:0]       up_source,
  input  logic [3:0]       up_target,
  input  logic [7:0]       up_data,
  output logic             valid_in,
  output logic [3:0]       source_in,
  output logic [3:0]       target_in,
  output logic [7:0]       data_in,
  input  logic             sw_ready,
  output logic [CNT_W-1:0] acc_cnt,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             full,
  output logic             empty
);

  localparam int         AW        = $clog2(DEPTH);
  localparam logic [3:0] PORT_MASK = 4'(1 << PORT_ID);
  localparam logic [0:0] IDLE      = 1'b0;
  localparam logic [0:0] HOLD      = 1'b1;

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [15:0]      mem_q [DEPTH];
  logic [15:0]      mem_d [DEPTH];
  logic [0:0]       state_q, state_d;
  logic [15:0]      out_q, out_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic             full_s, empty_s, xfer_s, legal_s, push_s, pop_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    if (en && (v != {CNT_W{1'b1}})) begin
      return v + CNT_W'(1);
    end else begin
      return v;
    end
  endfunction

  assign full_s  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign empty_s = (wr_ptr_q == rd_ptr_q);
  // Ready depends on registered occupancy only; a same-cycle pop never opens a slot.
  assign xfer_s  = up_valid && !full_s;
  assign legal_s = (up_target != 4'b0000) && ((up_target & PORT_MASK) == 4'b0000) &&
                   (up_source == PORT_MASK);
  assign push_s  = xfer_s && legal_s;

  assign up_ready  = !full_s;
  assign full      = full_s;
  assign empty     = empty_s;
  assign valid_in  = (state_q == HOLD);
  assign source_in = out_q[15:12];
  assign target_in = out_q[11:8];
  assign data_in   = out_q[7:0];
  assign acc_cnt   = acc_q;
  assign drop_cnt  = drop_q;

  // Output-stage FSM: load the head when idle, reload back-to-back on accept.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    pop_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty_s) begin
          pop_s   = 1'b1;
          out_d   = mem_q[rd_ptr_q[AW-1:0]];
          state_d = HOLD;
        end else begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (sw_ready) begin
          if (!empty_s) begin
            pop_s   = 1'b1;
            out_d   = mem_q[rd_ptr_q[AW-1:0]];
            state_d = HOLD;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FIFO storage, pointers and counters; pointer overflow carries into the wrap bit.
  always_comb begin
    mem_d = mem_q;
    if (push_s) begin
      mem_d[wr_ptr_q[AW-1:0]] = {up_source, up_target, up_data};
    end else begin
      mem_d[wr_ptr_q[AW-1:0]] = mem_q[wr_ptr_q[AW-1:0]];
    end
    wr_ptr_d = push_s ? (wr_ptr_q + (AW+1)'(1)) : wr_ptr_q;
    rd_ptr_d = pop_s  ? (rd_ptr_q + (AW+1)'(1)) : rd_ptr_q;
    acc_d    = sat_inc(acc_q, push_s);
    drop_d   = sat_inc(drop_q, xfer_s && !legal_s);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      state_q  <= IDLE;
      out_q    <= 16'h0000;
      acc_q    <= '0;
      drop_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 16'h0000;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      state_q  <= state_d;
      out_q    <= out_d;
      acc_q    <= acc_d;
      drop_q   <= drop_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: tb/tb_switch_ingress_buffer.sv
// Scoreboard bench for switch_ingress_buffer (PORT_ID=1); a second CNT_W=4 instance
// shares the stimulus and is used for counter saturation.
module tb_switch_ingress_buffer;
  logic        clk = 1'b0;
  logic        rst_n, up_valid, sw_ready;
  logic [3:0]  up_source, up_target;
  logic [7:0]  up_data;
  logic        up_ready, valid_in, full, empty;
  logic [3:0]  source_in, target_in;
  logic [7:0]  data_in;
  logic [15:0] acc_cnt, drop_cnt;
  logic        up_ready_s, valid_in_s, full_s, empty_s;
  logic [3:0]  source_in_s, target_in_s;
  logic [7:0]  data_in_s;
  logic [3:0]  acc_cnt_s, drop_cnt_s;

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [15:0] exp_q[$];
  logic [15:0] obs_mem [256];
  int          obs_cyc [256];
  int          obs_wr = 0;
  int          obs_rd = 0;
  int          cyc = 0;

  switch_ingress_buffer #(.PORT_ID(1), .DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .up_valid(up_valid), .up_ready(up_ready),
    .up_source(up_source), .up_target(up_target), .up_data(up_data),
    .valid_in(valid_in), .source_in(source_in), .target_in(target_in), .data_in(data_in),
    .sw_ready(sw_ready), .acc_cnt(acc_cnt), .drop_cnt(drop_cnt), .full(full), .empty(empty));

  switch_ingress_buffer #(.PORT_ID(1), .DEPTH(4), .CNT_W(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .up_valid(up_valid), .up_ready(up_ready_s),
    .up_source(up_source), .up_target(up_target), .up_data(up_data),
    .valid_in(valid_in_s), .source_in(source_in_s), .target_in(target_in_s), .data_in(data_in_s),
    .sw_ready(sw_ready), .acc_cnt(acc_cnt_s), .drop_cnt(drop_cnt_s), .full(full_s), .empty(empty_s));

  always #5 clk = ~clk;

  // Record every packet the switch port accepts (handshake completes on the next rising edge).
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (rst_n && valid_in && sw_ready) begin
      obs_mem[obs_wr % 256] = {source_in, target_in, data_in};
      obs_cyc[obs_wr % 256] = cyc;
      obs_wr = obs_wr + 1;
    end
  end

  function automatic bit legal(input logic [3:0] s, input logic [3:0] t);
    return (t != 4'b0000) && ((t & 4'b0010) == 4'b0000) && (s == 4'b0010);
  endfunction

  task automatic apply_reset();
    rst_n = 1'b0; up_valid = 1'b0; sw_ready = 1'b0;
    up_source = 4'h0; up_target = 4'h0; up_data = 8'h00;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    obs_rd = obs_wr;
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [3:0] s, input logic [3:0] t, input logic [7:0] d);
    bit done = 1'b0;
    up_valid = 1'b1; up_source = s; up_target = t; up_data = d;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (up_ready) done = 1'b1;
    end
    if (!done) begin
      vec_cnt++; err_cnt++;
      $display("FAIL send_timeout data=%h got up_ready=%b want 1", d, up_ready);
    end else begin
      @(posedge clk);
      if (legal(s, t)) exp_q.push_back({s, t, d});
    end
    #1 up_valid = 1'b0;
  endtask

  task automatic test_reset();
    bit seen = 1'b0;
    apply_reset();
    vec_cnt++;
    if ({valid_in, up_ready, empty, full, acc_cnt, drop_cnt} !== {4'b0110, 32'h0}) begin
      err_cnt++;
      $display("FAIL reset_state got v=%b r=%b e=%b f=%b acc=%0d drop=%0d want 0 1 1 0 0 0",
               valid_in, up_ready, empty, full, acc_cnt, drop_cnt);
    end
    send(4'b0010, 4'b0100, 8'h3C);
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = valid_in;
    end
    #2 rst_n = 1'b0;
    #1;
    vec_cnt++;
    if ({valid_in, source_in, target_in, data_in, up_ready, empty, full, acc_cnt} !==
        {17'h0, 3'b110, 16'h0} || !seen) begin
      err_cnt++;
      $display("FAIL reset_midpkt seen=%b got v=%b %h/%h/%h r=%b e=%b acc=%0d want v=0 0/0/00 r=1 e=1 acc=0",
               seen, valid_in, source_in, target_in, data_in, up_ready, empty, acc_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    obs_rd = obs_wr;
    repeat (3) @(negedge clk);
    vec_cnt++;
    if (valid_in !== 1'b0 || obs_wr != obs_rd) begin
      err_cnt++;
      $display("FAIL reset_idle got valid_in=%b deliveries=%0d want 0 0", valid_in, obs_wr - obs_rd);
    end
  endtask

  task automatic test_single();
    logic [15:0] e, g;
    apply_reset();
    sw_ready = 1'b1;
    send(4'b0010, 4'b0100, 8'hA5);
    vec_cnt++;
    if (valid_in !== 1'b0 || empty !== 1'b0 || acc_cnt !== 16'd1) begin
      err_cnt++;
      $display("FAIL single_n got v=%b e=%b acc=%0d want 0 0 1", valid_in, empty, acc_cnt);
    end
    @(posedge clk); #1;
    vec_cnt++;
    if ({valid_in, source_in, target_in, data_in} !== {1'b1, 4'b0010, 4'b0100, 8'hA5}) begin
      err_cnt++;
      $display("FAIL single_n1 got v=%b %b/%b/%h want 1 0010/0100/a5",
               valid_in, source_in, target_in, data_in);
    end
    @(posedge clk); #1;
    vec_cnt++;
    if (valid_in !== 1'b0) begin
      err_cnt++;
      $display("FAIL single_n2 got valid_in=%b want 0", valid_in);
    end
    for (int k = 0; k < 1; k++) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
      g = (obs_wr != obs_rd) ? obs_mem[obs_rd % 256] : 16'hxxxx;
      if (obs_wr != obs_rd) obs_rd++;
      vec_cnt++;
      if (g !== e) begin
        err_cnt++;
        $display("FAIL single_sb got %h want %h", g, e);
      end
    end
  endtask

  task automatic test_filter();
    apply_reset();
    sw_ready = 1'b1;
    send(4'b0010, 4'b0000, 8'h11);
    send(4'b0010, 4'b0010, 8'h22);
    send(4'b0001, 4'b0100, 8'h33);
    repeat (4) @(negedge clk);
    vec_cnt++;
    if (drop_cnt !== 16'd3 || acc_cnt !== 16'd0 || up_ready !== 1'b1 ||
        valid_in !== 1'b0 || obs_wr != obs_rd) begin
      err_cnt++;
      $display("FAIL filter got drop=%0d acc=%0d r=%b v=%b deliv=%0d want 3 0 1 0 0",
               drop_cnt, acc_cnt, up_ready, valid_in, obs_wr - obs_rd);
    end
  endtask

  task automatic test_full();
    logic [15:0] e, g;
    int c [6];
    apply_reset();
    for (int i = 1; i <= 5; i++) send(4'b0010, 4'b1000, 8'(i));
    up_valid = 1'b1; up_source = 4'b0010; up_target = 4'b1000; up_data = 8'd6;
    @(negedge clk);
    vec_cnt++;
    if ({full, up_ready, valid_in, data_in, acc_cnt} !== {3'b101, 8'd1, 16'd5}) begin
      err_cnt++;
      $display("FAIL full_state got f=%b r=%b v=%b d=%h acc=%0d want 1 0 1 01 5",
               full, up_ready, valid_in, data_in, acc_cnt);
    end
    repeat (2) @(negedge clk);
    vec_cnt++;
    if (valid_in !== 1'b1 || data_in !== 8'd1 || up_ready !== 1'b0) begin
      err_cnt++;
      $display("FAIL full_hold got v=%b d=%h r=%b want 1 01 0", valid_in, data_in, up_ready);
    end
    @(posedge clk); #1;
    sw_ready = 1'b1;
    send(4'b0010, 4'b1000, 8'd6);
    for (int i = 0; i < 100 && (obs_wr - obs_rd) < 6; i++) @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
      g = (obs_wr != obs_rd) ? obs_mem[obs_rd % 256] : 16'hxxxx;
      c[k] = (obs_wr != obs_rd) ? obs_cyc[obs_rd % 256] : -100;
      if (obs_wr != obs_rd) obs_rd++;
      vec_cnt++;
      if (g !== e || g[7:0] !== 8'(k + 1)) begin
        err_cnt++;
        $display("FAIL full_order[%0d] got %h want %h", k, g, e);
      end
    end
    for (int k = 1; k < 6; k++) begin
      vec_cnt++;
      if (c[k] != c[k-1] + 1) begin
        err_cnt++;
        $display("FAIL full_b2b[%0d] got gap=%0d want 1", k, c[k] - c[k-1]);
      end
    end
    @(posedge clk); #1;
    vec_cnt++;
    if (empty !== 1'b1 || valid_in !== 1'b0 || acc_cnt !== 16'd6) begin
      err_cnt++;
      $display("FAIL full_drain got e=%b v=%b acc=%0d want 1 0 6", empty, valid_in, acc_cnt);
    end
  endtask

  task automatic test_stream();
    logic [15:0] e, g;
    logic [3:0] tg [4] = '{4'b0001, 4'b0100, 4'b1000, 4'b1101};
    apply_reset();
    sw_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 20; i++) send(4'b0010, tg[i % 4], 8'(8'h40 + i));
      end
      begin
        for (int i = 0; i < 400 && (obs_wr - obs_rd) < 20; i++) begin
          @(posedge clk); #1 sw_ready = ~sw_ready;
        end
      end
    join
    sw_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
      g = (obs_wr != obs_rd) ? obs_mem[obs_rd % 256] : 16'hxxxx;
      if (obs_wr != obs_rd) obs_rd++;
      vec_cnt++;
      if (g !== e || g[7:0] !== 8'(8'h40 + k)) begin
        err_cnt++;
        $display("FAIL stream[%0d] got %h want %h", k, g, e);
      end
    end
    repeat (3) @(negedge clk);
    vec_cnt++;
    if (acc_cnt !== 16'd20 || empty !== 1'b1 || valid_in !== 1'b0 || obs_wr != obs_rd) begin
      err_cnt++;
      $display("FAIL stream_end got acc=%0d e=%b v=%b extra=%0d want 20 1 0 0",
               acc_cnt, empty, valid_in, obs_wr - obs_rd);
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    sw_ready = 1'b1;
    for (int i = 0; i < 17; i++) send(4'b0001, 4'b0100, 8'(i));
    vec_cnt++;
    if (drop_cnt_s !== 4'hF || drop_cnt !== 16'd17 || acc_cnt_s !== 4'h0) begin
      err_cnt++;
      $display("FAIL sat_17 got drop4=%0d drop16=%0d acc4=%0d want 15 17 0",
               drop_cnt_s, drop_cnt, acc_cnt_s);
    end
    send(4'b0010, 4'b0000, 8'hEE);
    vec_cnt++;
    if (drop_cnt_s !== 4'hF || drop_cnt !== 16'd18) begin
      err_cnt++;
      $display("FAIL sat_hold got drop4=%0d drop16=%0d want 15 18", drop_cnt_s, drop_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_filter();
    test_full();
    test_stream();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
